// File: rtl/knn_topk_vote.sv
`default_nettype none
// ============================================================================
//  Module      : knn_topk_vote
//  Description : Streaming K-nearest-neighbour selector and majority voter.
//                Keeps an ascending-distance top-K_MAX list of incoming
//                (distance, class) samples. It then votes one class per
//                cycle over the first K_eff entries and reports the winning
//                class, the vote count, a tie flag and the start-to-done
//                latency.
//                Optional macro KNN_TIE_NEAREST_EN: equal-count ties go to
//                the class that owns the nearest neighbour. Without it, the
//                lowest class index wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module knn_topk_vote #(
    parameter int DIST_W  = 16,
    parameter int CLASS_W = 2,
    parameter int K_MAX   = 7,
    parameter int LAT_W   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [$clog2(K_MAX+1)-1:0]   k_sel,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DIST_W-1:0]            s_dist,
    input  logic [CLASS_W-1:0]           s_class,
    input  logic                         s_last,
    output logic                         busy,
    output logic                         done,
    output logic [CLASS_W-1:0]           predicted_class,
    output logic [$clog2(K_MAX+1)-1:0]   vote_count,
    output logic                         tie,
    output logic [LAT_W-1:0]             latency
);

    localparam int K_W = $clog2(K_MAX + 1);
    localparam logic [K_W-1:0]     c_K_MAX    = K_W'(K_MAX);
    localparam logic [CLASS_W-1:0] c_LAST_CLS = {CLASS_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VOTE    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Sorted neighbour list; valid entries always form a prefix.
    logic [DIST_W-1:0]  r_dist [K_MAX];
    logic [CLASS_W-1:0] r_lbl  [K_MAX];
    logic [K_MAX-1:0]   r_vld;

    logic [DIST_W-1:0]  w_dist_nxt [K_MAX];
    logic [CLASS_W-1:0] w_lbl_nxt  [K_MAX];
    logic [K_MAX-1:0]   w_vld_nxt;
    logic [K_MAX-1:0]   w_lt;

    logic               w_start_acc;
    logic               w_beat;
    logic               w_vote_last;
    logic [K_W-1:0]     w_keff;

    logic [K_W-1:0]     r_keff;
    logic [CLASS_W-1:0] r_vcls;
    logic [CLASS_W-1:0] r_best_cls;
    logic [K_W-1:0]     r_best_cnt;
    logic               r_tie;

    logic [K_MAX-1:0]   w_match;
    logic [K_W-1:0]     w_cnt;
    logic               w_eq;
    logic [CLASS_W-1:0] w_best_cls_nxt;
    logic [K_W-1:0]     w_best_cnt_nxt;
    logic               w_tie_nxt;

`ifdef KNN_TIE_NEAREST_EN
    logic [K_W-1:0]     r_best_pos;
    logic [K_W-1:0]     w_pos;
    logic [K_W-1:0]     w_best_pos_nxt;
`endif

    logic [LAT_W-1:0]   r_latency;
    logic [CLASS_W-1:0] r_pred;
    logic [K_W-1:0]     r_vcount;
    logic               r_tie_out;

    assign w_start_acc = start && (r_state == S_IDLE);
    assign w_beat      = s_valid && (r_state == S_COLLECT);
    assign w_vote_last = (r_state == S_VOTE) && (r_vcls == c_LAST_CLS);

    // Runtime K clamped into 1..K_MAX.
    always_comb begin
        w_keff = k_sel;
        if (k_sel == '0) begin
            w_keff = K_W'(1);
        end else if (k_sel > c_K_MAX) begin
            w_keff = c_K_MAX;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid && s_last) begin
                    w_state_nxt = S_VOTE;
                end
            end
            S_VOTE: begin
                busy = 1'b1;
                if (r_vcls == c_LAST_CLS) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Parallel compare-shift insertion. Because the list is sorted and the
    // compare is strict, w_lt is monotonic: the new sample lands at the first
    // position that compares less, and everything behind it moves down one.
    generate
        for (genvar gi = 0; gi < K_MAX; gi++) begin : g_ins
            assign w_lt[gi] = !r_vld[gi] || (s_dist < r_dist[gi]);
            if (gi == 0) begin : g_head
                assign w_dist_nxt[gi] = w_lt[gi] ? s_dist  : r_dist[gi];
                assign w_lbl_nxt[gi]  = w_lt[gi] ? s_class : r_lbl[gi];
                assign w_vld_nxt[gi]  = w_lt[gi] | r_vld[gi];
            end else begin : g_tail
                assign w_dist_nxt[gi] = !w_lt[gi]     ? r_dist[gi]   :
                                        !w_lt[gi-1]   ? s_dist       : r_dist[gi-1];
                assign w_lbl_nxt[gi]  = !w_lt[gi]     ? r_lbl[gi]    :
                                        !w_lt[gi-1]   ? s_class      : r_lbl[gi-1];
                assign w_vld_nxt[gi]  = !w_lt[gi]     ? r_vld[gi]    :
                                        !w_lt[gi-1]   ? 1'b1         : r_vld[gi-1];
            end
        end
    endgenerate

    // Neighbour list storage: emptied on start, updated on each accepted beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < K_MAX; i++) begin
                r_dist[i] <= '0;
                r_lbl[i]  <= '0;
            end
            r_vld <= '0;
        end else if (w_start_acc) begin
            r_vld <= '0;
        end else if (w_beat) begin
            for (int i = 0; i < K_MAX; i++) begin
                r_dist[i] <= w_dist_nxt[i];
                r_lbl[i]  <= w_lbl_nxt[i];
            end
            r_vld <= w_vld_nxt;
        end
    end

    // Votes for the class under evaluation among the first K_eff entries.
    always_comb begin
        w_match = '0;
        w_cnt   = '0;
        for (int i = 0; i < K_MAX; i++) begin
            w_match[i] = r_vld[i] && (K_W'(i) < r_keff) && (r_lbl[i] == r_vcls);
            if (w_match[i]) begin
                w_cnt = w_cnt + K_W'(1);
            end
        end
    end

`ifdef KNN_TIE_NEAREST_EN
    // Position of the nearest entry voting for the current class.
    always_comb begin
        w_pos = c_K_MAX;
        for (int i = K_MAX - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_pos = K_W'(i);
            end
        end
    end
`endif

    // Running-best update. Tie is cleared by a strictly larger count and set
    // whenever the best and another class end up with equal non-zero counts.
    always_comb begin
        w_best_cls_nxt = r_best_cls;
        w_best_cnt_nxt = r_best_cnt;
        w_tie_nxt      = r_tie;
`ifdef KNN_TIE_NEAREST_EN
        w_best_pos_nxt = r_best_pos;
`endif
        w_eq = (w_cnt == r_best_cnt) && (w_cnt != '0);
        if (w_cnt > r_best_cnt) begin
            w_best_cls_nxt = r_vcls;
            w_best_cnt_nxt = w_cnt;
            w_tie_nxt      = 1'b0;
`ifdef KNN_TIE_NEAREST_EN
            w_best_pos_nxt = w_pos;
        end else if (w_eq && (w_pos < r_best_pos)) begin
            w_best_cls_nxt = r_vcls;
            w_best_pos_nxt = w_pos;
            w_tie_nxt      = 1'b1;
`endif
        end else if (w_eq) begin
            w_tie_nxt = 1'b1;
        end
    end

    // Query setup, vote sequencing, latency counting and result registers.
    // The start cycle is cycle 0, so the first busy cycle reads latency 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_keff     <= '0;
            r_vcls     <= '0;
            r_best_cls <= '0;
            r_best_cnt <= '0;
            r_tie      <= 1'b0;
`ifdef KNN_TIE_NEAREST_EN
            r_best_pos <= '0;
`endif
            r_latency  <= '0;
            r_pred     <= '0;
            r_vcount   <= '0;
            r_tie_out  <= 1'b0;
        end else if (w_start_acc) begin
            r_keff     <= w_keff;
            r_vcls     <= '0;
            r_best_cls <= '0;
            r_best_cnt <= '0;
            r_tie      <= 1'b0;
`ifdef KNN_TIE_NEAREST_EN
            r_best_pos <= c_K_MAX;
`endif
            r_latency  <= LAT_W'(1);
        end else begin
            if ((r_state == S_COLLECT || r_state == S_VOTE) && (r_latency != '1)) begin
                r_latency <= r_latency + LAT_W'(1);
            end
            if (r_state == S_VOTE) begin
                r_best_cls <= w_best_cls_nxt;
                r_best_cnt <= w_best_cnt_nxt;
                r_tie      <= w_tie_nxt;
`ifdef KNN_TIE_NEAREST_EN
                r_best_pos <= w_best_pos_nxt;
`endif
                r_vcls     <= r_vcls + CLASS_W'(1);
                if (w_vote_last) begin
                    r_pred    <= w_best_cls_nxt;
                    r_vcount  <= w_best_cnt_nxt;
                    r_tie_out <= w_tie_nxt;
                end
            end
        end
    end

    assign predicted_class = r_pred;
    assign vote_count      = r_vcount;
    assign tie             = r_tie_out;
    assign latency         = r_latency;

endmodule
`default_nettype wire
